// File: rtl/uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TX FIFO fed from the CPU bus, shift-register FSM on tx.
// Registers: 0 TXDATA (wo), 1 STATUS {ovf,busy,empty,full}, 2 DIV (bit period DIV+1 clocks), 3 reserved.
module uart_tx #(
  parameter int         DEPTH     = 4,
  parameter logic [7:0] DIV_RESET = 8'd3
) (
  input  logic       clk,
  input  logic       reset,
  inout  wire  [7:0] data_bus,
  input  logic [1:0] address,
  input  logic       cs,
  input  logic       write,
  input  logic       read,
  output logic       tx
);
  localparam int         AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [7:0]    div;
  logic [7:0]    shift;
  logic [7:0]    bit_cnt;
  logic [2:0]    bit_idx;
  logic          overflow;

  logic          full;
  logic          empty;
  logic          boundary;
  logic          pop;
  logic          push_req;
  logic          push;
  logic          stat_rd;
  logic [7:0]    rd_data;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign boundary = (bit_cnt == 8'd0);
  assign pop      = !empty && ((state == IDLE) || ((state == STOP) && boundary));
  assign push_req = cs && write && (address == 2'd0);
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push     = push_req && (!full || pop);
  assign stat_rd  = cs && read && (address == 2'd1);

  always_comb begin
    rd_data = 8'h00;
    case (address)
      2'd1:    rd_data = {4'b0000, overflow, (state != IDLE), empty, full};
      2'd2:    rd_data = div;
      default: rd_data = 8'h00;
    endcase
  end

  assign data_bus = (cs && read) ? rd_data : 8'hzz;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= data_bus;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      div      <= DIV_RESET;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A fresh drop outranks the clear-on-read.
      if (push_req && !push) begin
        overflow <= 1'b1;
      end else if (stat_rd) begin
        overflow <= 1'b0;
      end
      if (cs && write && (address == 2'd2)) begin
        div <= data_bus;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      tx      <= 1'b1;
      shift   <= 8'h00;
      bit_cnt <= 8'h00;
      bit_idx <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (!empty) begin
            state   <= START;
            tx      <= 1'b0;
            shift   <= mem[rd_ptr];
            bit_cnt <= div;
          end
        end
        START: begin
          if (boundary) begin
            state   <= DATA;
            tx      <= shift[0];
            bit_cnt <= div;
            bit_idx <= 3'd0;
          end else begin
            bit_cnt <= bit_cnt - 8'd1;
          end
        end
        DATA: begin
          if (boundary) begin
            bit_cnt <= div;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= shift >> 1;
              tx      <= shift[1];
            end
          end else begin
            bit_cnt <= bit_cnt - 8'd1;
          end
        end
        STOP: begin
          if (boundary) begin
            // Back-to-back: next start bit begins on the edge that ends this stop bit.
            if (!empty) begin
              state   <= START;
              tx      <= 1'b0;
              shift   <= mem[rd_ptr];
              bit_cnt <= div;
            end else begin
              state <= IDLE;
              tx    <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt - 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: bit-level line model checked every cycle, plus literal waveform/status checks.
module tb_uart_tx;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  wire  [7:0] data_bus;
  logic [1:0] address = 2'd0;
  logic       cs = 1'b0;
  logic       write = 1'b0;
  logic       read = 1'b0;
  logic       tx;
  logic       tb_drv = 1'b0;
  logic [7:0] tb_dat = 8'h00;

  int total = 0;
  int bad = 0;

  assign data_bus = tb_drv ? tb_dat : 8'hzz;

  uart_tx #(.DEPTH(DEPTH), .DIV_RESET(8'd3)) dut (
    .clk(clk), .reset(reset), .data_bus(data_bus), .address(address),
    .cs(cs), .write(write), .read(read), .tx(tx)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Line model: a queue of pending line bits, each held for DIV+1 clocks using DIV at its start.
  logic [7:0] mq[$];
  logic       bits[$];
  logic [7:0] sent[$];
  int         rem = 0;
  logic       exp_tx = 1'b1;
  logic       exp_busy = 1'b0;
  logic       m_ovf = 1'b0;
  logic [7:0] m_div = 8'd3;
  logic [7:0] m_byte;

  function automatic logic [7:0] exp_status();
    return {4'b0000, m_ovf, exp_busy, mq.size() == 0, mq.size() == DEPTH};
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      bits.delete();
      rem = 0;
      exp_tx = 1'b1;
      exp_busy = 1'b0;
      m_ovf = 1'b0;
      m_div = 8'd3;
    end else begin
      if (rem == 0) begin
        if (bits.size() == 0 && mq.size() > 0) begin
          m_byte = mq.pop_front();
          sent.push_back(m_byte);
          bits.push_back(1'b0);
          for (int i = 0; i < 8; i++) bits.push_back(m_byte[i]);
          bits.push_back(1'b1);
        end
        if (bits.size() > 0) begin
          exp_tx = bits.pop_front();
          rem = int'(m_div);
          exp_busy = 1'b1;
        end else begin
          exp_tx = 1'b1;
          exp_busy = 1'b0;
        end
      end else begin
        rem--;
      end
      if (cs && write && address == 2'd0) begin
        if (mq.size() < DEPTH) mq.push_back(tb_dat);
        else m_ovf = 1'b1;
      end else if (cs && read && address == 2'd1) begin
        m_ovf = 1'b0;
      end
      if (cs && write && address == 2'd2) m_div = tb_dat;
    end
  end

  always @(negedge clk) begin
    total++;
    if (tx !== exp_tx) begin
      bad++;
      $display("FAIL tx_cycle t=%0t: got %b expected %b", $time, tx, exp_tx);
    end
  end

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; write = 1'b1; read = 1'b0; address = a; tb_drv = 1'b1; tb_dat = d;
  endtask

  task automatic rd(input logic [1:0] a, input logic [7:0] lit, input string name);
    logic [7:0] got;
    @(negedge clk);
    cs = 1'b1; write = 1'b0; read = 1'b1; address = a; tb_drv = 1'b0;
    #1;
    got = data_bus;
    check(name, 64'(got), 64'(lit));
    if (a == 2'd1) check({name, "_model"}, 64'(exp_status()), 64'(lit));
  endtask

  task automatic bus_idle();
    @(negedge clk);
    cs = 1'b0; write = 1'b0; read = 1'b0; tb_drv = 1'b0;
  endtask

  logic [39:0] s40;
  logic [19:0] s20;
  logic [11:0] s12;
  logic [7:0]  exp_sent [11] = '{8'h55, 8'hA5, 8'h3C, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'hFF, 8'h81, 8'h0F};

  initial begin
    #1 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state
    check("reset_tx", 64'(tx), 64'd1);
    rd(2'd1, 8'h02, "reset_status");
    rd(2'd2, 8'h03, "reset_div");
    rd(2'd0, 8'h00, "txdata_read");
    rd(2'd3, 8'h00, "reg3_read");
    @(negedge clk);
    cs = 1'b0; read = 1'b0; write = 1'b0; tb_drv = 1'b1; tb_dat = 8'h5A;
    #1 check("bus_released", 64'(data_bus), 64'h5A);
    bus_idle();

    // 0x55 at DIV=3
    wr(2'd0, 8'h55);
    bus_idle();
    check("no_fall_at_write_edge", 64'(tx), 64'd1);
    for (int i = 0; i < 39; i++) begin
      @(negedge clk);
      s40[39 - i] = tx;
    end
    rd(2'd1, 8'h06, "busy_last_stop");
    s40[0] = tx;
    check("frame_55", 64'(s40), 64'h0F0F0F0F0F);
    rd(2'd1, 8'h02, "idle_after_frame");
    bus_idle();

    // DIV=0, back-to-back frames
    wr(2'd2, 8'h00);
    wr(2'd0, 8'hA5);
    wr(2'd0, 8'h3C);
    bus_idle();
    s20[19] = tx;
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      s20[18 - i] = tx;
    end
    check("frames_a5_3c", 64'(s20), 64'h52C79);
    repeat (3) @(negedge clk);

    // Overflow with DIV=3
    wr(2'd2, 8'h03);
    bus_idle();
    repeat (2) @(negedge clk);
    for (int b = 1; b <= 6; b++) wr(2'd0, 8'(b));
    bus_idle();
    rd(2'd1, 8'h0D, "status_overflow");
    rd(2'd1, 8'h05, "status_ovf_cleared");
    bus_idle();
    repeat (210) @(negedge clk);
    rd(2'd1, 8'h02, "status_drained");
    bus_idle();

    // Reset mid-frame
    wr(2'd0, 8'hFF);
    bus_idle();
    repeat (20) @(negedge clk);
    #2 reset = 1'b1;
    #1 check("tx_high_in_reset", 64'(tx), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    rd(2'd1, 8'h02, "status_after_reset");
    rd(2'd2, 8'h03, "div_after_reset");
    wr(2'd0, 8'h81);
    bus_idle();
    check("idle_before_81", 64'(tx), 64'd1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      s40[39 - i] = tx;
    end
    check("frame_81", 64'(s40), 64'h0F000000FF);

    // DIV change during start bit
    wr(2'd0, 8'h0F);
    wr(2'd2, 8'h07);
    bus_idle();
    s12[11] = tx;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      s12[10 - i] = tx;
    end
    check("div_change_start", 64'(s12), 64'h0FF);
    repeat (85) @(negedge clk);
    rd(2'd1, 8'h02, "final_status");
    rd(2'd2, 8'h07, "final_div");
    bus_idle();

    check("sent_count", 64'(sent.size()), 64'd11);
    for (int i = 0; i < 11 && i < sent.size(); i++) check($sformatf("sent_%0d", i), 64'(sent[i]), 64'(exp_sent[i]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
